mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning: consecutive data grants tolerated while fetch waits (range 1-7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch stage requests instruction read; held high until imem_r.
REQ-005 if_addr  input  16  fetch address (PC).
REQ-006 if_flush  input  1  fetch redirect (branch/trap taken); outstanding fetch result discarded.
REQ-007 d_req  input  1  memory stage requests data access; held high until d_r.
REQ-008 d_we  input  1  1 = write, 0 = read.
REQ-009 d_addr  input  16  data address.
REQ-010 d_wdata  input  16  write data.
REQ-011 mem_ack  input  1  memory completes current access this cycle.
REQ-012 mem_rdata  input  16  read data, valid with mem_ack.
REQ-013 mem_req  output  1  access active to shared memory port.
REQ-014 mem_we  output  1  write strobe for current access.
REQ-015 mem_addr  output  16  latched access address.
REQ-016 mem_wdata  output  16  latched write data.
REQ-017 imem_r  output  1  instruction ready pulse to fetch stage.
REQ-018 instr  output  16  instruction word, valid when imem_r.
REQ-019 d_r  output  1  data access complete pulse to memory stage.
REQ-020 d_rdata  output  16  read data, valid when d_r and access was a read.

Function
REQ-021 FSM states SHALL be IDLE, IF_BUSY, D_BUSY, IF_DROP.
REQ-022 IDLE: grant data (go D_BUSY) if d_req and not (if_req and !if_flush and starve_cnt == STARVE_LIMIT); else grant fetch (go IF_BUSY) if if_req and !if_flush; else stay.
REQ-023 On grant, address/we/wdata SHALL be registered; fetch grant forces mem_we = 0, mem_wdata unchanged.
REQ-024 mem_req SHALL equal 1 exactly in IF_BUSY, D_BUSY, IF_DROP; mem_addr/mem_we/mem_wdata stable throughout each busy period.
REQ-025 Busy state with mem_ack = 1 -> IDLE next cycle; without mem_ack stays (no timeout, no preemption).
REQ-026 imem_r = (state == IF_BUSY) and mem_ack and !if_flush; instr = mem_rdata (combinational).
REQ-027 d_r = (state == D_BUSY) and mem_ack; d_rdata = mem_rdata (combinational).
REQ-028 IF_BUSY with if_flush and no mem_ack -> IF_DROP; IF_DROP holds mem_req until mem_ack, then IDLE with imem_r = 0.
REQ-029 IF_BUSY with if_flush and mem_ack same cycle -> IDLE, imem_r = 0 (flush wins).
REQ-030 if_flush in IDLE blocks fetch grant that cycle only; data grant unaffected.
REQ-031 mem_ack in IDLE SHALL be ignored (no pulse, no state change).
REQ-032 starve_cnt (3 bits): on data grant with if_req high -> increment, saturate at STARVE_LIMIT; on data grant with if_req low -> 0; on fetch grant -> 0.
REQ-033 imem_r and d_r SHALL never be high in same cycle; each pulse exactly one cycle per transaction.
REQ-034 Minimum transaction: grant cycle N, mem_req from N+1, ack at N+1 gives ready at N+1, IDLE at N+2.

Reset
REQ-035 reset SHALL immediately force state IDLE, starve_cnt 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, imem_r 0, d_r 0.
REQ-036 reset mid-transaction SHALL abandon the access; a late mem_ack after release is ignored per REQ-031.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x3000, ack after 3 busy cycles, rdata=0x1234 -> mem_req 3 cycles, mem_addr=0x3000, mem_we=0, imem_r pulse with instr=0x1234.
REQ-038 Simultaneous if_req and d_req (d_we=1, d_addr=0x4000, d_wdata=0xBEEF), starve_cnt=0 -> D_BUSY first with mem_we=1, d_r pulse, then fetch granted.
REQ-039 Starvation: d_req and if_req continuously high, STARVE_LIMIT=4, ack each busy cycle -> exactly 4 data grants then 1 fetch grant, repeating.
REQ-040 Flush: if_flush pulsed 1 cycle in IF_BUSY, ack 2 cycles later -> IF_DROP entered, mem_req held, no imem_r; flush coincident with ack -> no imem_r.
REQ-041 Async reset asserted mid D_BUSY between clock edges -> mem_req and outputs 0 before next edge; ack after release produces no d_r.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one shared memory port between the fetch stage and the data stage, data first with a fetch starvation guard.
// Latency: grant in the IDLE cycle, mem_req from the next cycle, ready pulse in the cycle mem_ack arrives (minimum 1 busy cycle).
// Backpressure: requesters hold their request until their ready pulse; a busy access waits on mem_ack indefinitely, with no preemption.
//
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   if_req/if_addr/if_flush         - fetch request, PC, redirect (discards an outstanding fetch)
//   d_req/d_we/d_addr/d_wdata       - data request, write enable, address, write data
//   mem_ack/mem_rdata               - memory completion and read data
//   mem_req/mem_we/mem_addr/mem_wdata - registered access to the shared memory port
//   imem_r/instr                    - fetch completion pulse and instruction word
//   d_r/d_rdata                     - data completion pulse and read data
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        imem_r,
    output logic [15:0] instr,
    output logic        d_r,
    output logic [15:0] d_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        IF_DROP = 2'd3
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    logic [2:0] starve_cnt;
    logic       fetch_ok;
    logic       starved;

    // A flushing fetch is not a candidate this cycle, so it cannot claim the
    // starvation override either.
    assign fetch_ok = if_req && !if_flush;
    assign starved  = fetch_ok && (starve_cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !starved) begin
                        state     <= D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // Streak only counts while fetch is actually waiting.
                        if (if_req)
                            starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 3'd1;
                        else
                            starve_cnt <= 3'd0;
                    end else if (fetch_ok) begin
                        state      <= IF_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        starve_cnt <= 3'd0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (if_flush) begin
                        // Access already issued: keep the port until memory
                        // answers, then drop the result.
                        state <= IF_DROP;
                    end
                end
                D_BUSY, IF_DROP: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Flush in the completing cycle wins over delivering the instruction.
    assign imem_r  = (state == IF_BUSY) && mem_ack && !if_flush;
    assign d_r     = (state == D_BUSY) && mem_ack;
    assign instr   = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, d_req, d_we, mem_ack;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        mem_req, mem_we, imem_r, d_r;
    logic [15:0] mem_addr, mem_wdata, instr, d_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .imem_r    (imem_r),
        .instr     (instr),
        .d_r       (d_r),
        .d_rdata   (d_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ifr, fl, dr, dwe, ack;
        logic [15:0] ia, da, dw, rd;
        logic        e_req, e_we;
        logic [15:0] e_addr, e_wdata;
        logic        e_ir, e_dr;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model ----------------
    // owner: 0 = port free, 1 = fetch, 2 = data; dropped marks a fetch whose
    // result must be discarded. streak = data grants in a row while fetch waited.
    int          owner;
    bit          dropped;
    int          streak;
    logic        m_we;
    logic [15:0] m_addr, m_wdata;

    task automatic model_reset();
        owner = 0; dropped = 0; streak = 0;
        m_we = 0; m_addr = 0; m_wdata = 0;
    endtask

    task automatic model_step();
        bit want_f;
        want_f = if_req && !if_flush;
        if (owner == 0) begin
            if (d_req && !(want_f && streak >= LIM)) begin
                owner = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                streak = if_req ? ((streak + 1 > LIM) ? LIM : streak + 1) : 0;
            end else if (want_f) begin
                owner = 1; m_we = 0; m_addr = if_addr; streak = 0;
            end
        end else if (mem_ack) begin
            owner = 0; dropped = 0;
        end else if (owner == 1 && if_flush) begin
            dropped = 1;
        end
    endtask

    task automatic drive_idle();
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        drive_idle();
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    initial begin
        int   got;
        logic kind[16];
        logic exp_ir, exp_dr;

        reset = 1;
        drive_idle();
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_imem_r", imem_r, 0);
        chk("rst_d_r", d_r, 0);
        @(posedge clk);
        #1;
        reset = 0;

        //              ifr fl dr dwe ack  ia        da        dw        rd       req we addr      wdata     ir dr
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3000, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3000, 16'h4000, 16'hBEEF, 16'h0000, 1, 0, 16'h3000, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3000, 16'h4000, 16'hBEEF, 16'h0000, 1, 0, 16'h3000, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 16'h3000, 16'h4000, 16'hBEEF, 16'h1234, 1, 0, 16'h3000, 16'h0000, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 16'h3000, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h3000, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 16'h3002, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h3000, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 1, 16'h3002, 16'h4000, 16'hBEEF, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 0, 1});
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3002, 16'h4000, 16'hBEEF, 16'h0000, 0, 1, 16'h4000, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 16'h3002, 16'h4000, 16'hBEEF, 16'h5678, 1, 0, 16'h3002, 16'hBEEF, 1, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3004, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h3002, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 0, 16'h3004, 16'h4000, 16'hBEEF, 16'h0000, 1, 0, 16'h3004, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3004, 16'h4000, 16'hBEEF, 16'h0000, 1, 0, 16'h3004, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 16'h3004, 16'h4000, 16'hBEEF, 16'h1111, 1, 0, 16'h3004, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 16'h3008, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h3004, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 16'h3008, 16'h4000, 16'hBEEF, 16'h2222, 1, 0, 16'h3008, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 0, 16'h300A, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h3008, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 16'h300A, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h3008, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 16'h300A, 16'h4000, 16'hBEEF, 16'h2222, 1, 0, 16'h300A, 16'hBEEF, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 16'h300A, 16'h4000, 16'hBEEF, 16'h0000, 0, 0, 16'h300A, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 16'h300C, 16'h5000, 16'hBEEF, 16'h0000, 0, 0, 16'h300A, 16'hBEEF, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 1, 16'h300C, 16'h5000, 16'hBEEF, 16'h3333, 1, 0, 16'h5000, 16'hBEEF, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 16'h300C, 16'h5000, 16'hBEEF, 16'h0000, 0, 0, 16'h5000, 16'hBEEF, 0, 0});

        foreach (tbl[i]) begin
            if_req = tbl[i].ifr; if_flush = tbl[i].fl; d_req = tbl[i].dr; d_we = tbl[i].dwe;
            mem_ack = tbl[i].ack; if_addr = tbl[i].ia; d_addr = tbl[i].da;
            d_wdata = tbl[i].dw; mem_rdata = tbl[i].rd;
            #4;
            chk($sformatf("vec%0d_mem_req", i), mem_req, tbl[i].e_req);
            chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].e_we);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
            chk($sformatf("vec%0d_imem_r", i), imem_r, tbl[i].e_ir);
            chk($sformatf("vec%0d_d_r", i), d_r, tbl[i].e_dr);
            if (tbl[i].e_ir) chk($sformatf("vec%0d_instr", i), instr, tbl[i].rd);
            if (tbl[i].e_dr) chk($sformatf("vec%0d_d_rdata", i), d_rdata, tbl[i].rd);
            @(posedge clk);
            #1;
        end

        // Starvation: both requesters always on, ack every busy cycle.
        do_reset();
        if_req = 1; d_req = 1; d_we = 1; mem_ack = 1;
        if_addr = 16'h3100; d_addr = 16'h4100; d_wdata = 16'h0042;
        got = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            #4;
            if (d_r || imem_r) begin
                chk("starve_both_pulse", 32'(d_r && imem_r), 0);
                kind[got] = imem_r;
                got++;
            end
            @(posedge clk);
            #1;
        end
        chk("starve_pulse_count", got, 10);
        for (int i = 0; i < got; i++)
            chk($sformatf("starve_seq%0d_is_fetch", i), kind[i], (i % 5 == 4) ? 1'b1 : 1'b0);

        // Asynchronous reset in the middle of a data access.
        do_reset();
        d_req = 1; d_we = 1; d_addr = 16'h4444; d_wdata = 16'h5555;
        @(posedge clk);
        #1;
        d_req = 0;
        #1;
        chk("arst_pre_mem_req", mem_req, 1);
        chk("arst_pre_mem_addr", mem_addr, 16'h4444);
        #1;
        reset = 1;
        mem_ack = 1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_d_r", d_r, 0);
        #1;
        reset = 0;
        @(posedge clk);
        #4;
        chk("arst_late_ack_d_r", d_r, 0);
        chk("arst_late_ack_mem_req", mem_req, 0);
        @(posedge clk);
        #1;

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if_req    = ($urandom % 4) != 0;
            if_flush  = ($urandom % 8) == 0;
            d_req     = ($urandom % 3) != 0;
            d_we      = $urandom % 2;
            mem_ack   = ($urandom % 3) != 0;
            if_addr   = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            mem_rdata = 16'($urandom);
            #4;
            exp_ir = (owner == 1) && !dropped && mem_ack && !if_flush;
            exp_dr = (owner == 2) && mem_ack;
            chk("rnd_mem_req", mem_req, (owner != 0) ? 1 : 0);
            chk("rnd_mem_we", mem_we, m_we);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
            chk("rnd_imem_r", imem_r, exp_ir);
            chk("rnd_d_r", d_r, exp_dr);
            if (exp_ir) chk("rnd_instr", instr, mem_rdata);
            if (exp_dr) chk("rnd_d_rdata", d_rdata, mem_rdata);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
